// File: rtl/ysyx_23060061_ifu.sv
// ysyx_23060061_ifu -- instruction fetch unit for the multi-cycle core.
//
// Holds the PC and issues one word fetch at a time. The fetched word is
// registered and handed to the decoder. The unit then waits for the
// downstream stages to return the next PC before it fetches again.
//
// Parameters:
//   RESET_PC  PC loaded on reset.
//   TIMEOUT   maximum WAIT cycles before a fetch fault (8-bit counter).
//
// Ports:
//   clk, rst_n                        clock / async active-low reset
//   imem_req_valid/ready/addr         fetch request (addr == pc)
//   imem_resp_valid/data/err          one-cycle response strobe
//   inst_valid/ready, inst, inst_pc   instruction handoff to decoder
//   opcode, funct3                    pre-sliced fields of inst
//   npc_valid, npc                    next PC from downstream
//   fetch_fault                       sticky fault (cleared by reset only)
//
// Optional feature: define YSYX_23060061_IFU_ALIGN_CHECK_EN to send a
// misaligned npc (npc[1:0] != 0) to FAULT instead of fetching from it.
module ysyx_23060061_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        EXEC,
        FAULT
    } state_t;

    // Counter value on the edge that completes the TIMEOUT-th WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, stateNext;
    logic [31:0] pc;
    logic [31:0] instQ;
    logic [31:0] instPcQ;
    logic [7:0]  waitCnt;
    logic        npcBad;

`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
    assign npcBad = |npc[1:0];
`else
    assign npcBad = 1'b0;
`endif

    // Next-state logic. In WAIT a response beats the timeout on the same edge,
    // and an error response beats a good one.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  stateNext = FETCH;
            FETCH: if (imem_req_ready) stateNext = WAIT;
            WAIT: begin
                if (imem_resp_valid)
                    stateNext = imem_resp_err ? FAULT : ISSUE;
                else if (waitCnt == CNT_LAST)
                    stateNext = FAULT;
            end
            ISSUE: if (inst_ready) stateNext = EXEC;
            EXEC:  if (npc_valid) stateNext = npcBad ? FAULT : FETCH;
            FAULT: stateNext = FAULT;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instQ   <= '0;
            instPcQ <= RESET_PC;
            waitCnt <= '0;
        end else begin
            state <= stateNext;

            if (state == FETCH && imem_req_ready)
                waitCnt <= '0;
            else if (state == WAIT)
                waitCnt <= waitCnt + 8'd1;

            if (state == WAIT && imem_resp_valid && !imem_resp_err) begin
                instQ   <= imem_resp_data;
                instPcQ <= pc;
            end

            if (state == EXEC && npc_valid && !npcBad)
                pc <= npc;
        end
    end

    // Moore outputs.
    assign imem_req_valid = (state == FETCH);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == ISSUE);
    assign fetch_fault    = (state == FAULT);
    assign inst           = instQ;
    assign inst_pc        = instPcQ;
    assign opcode         = instQ[6:0];
    assign funct3         = instQ[14:12];

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
module tb_ysyx_23060061_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TIMEOUT  = 255;
`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid, imem_resp_err;
    logic [31:0] imem_resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        npc_valid;
    logic [31:0] npc;
    logic        fetch_fault;

    ysyx_23060061_ifu #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .imem_resp_err(imem_resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .opcode(opcode), .funct3(funct3),
        .npc_valid(npc_valid), .npc(npc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int cmpCnt = 0;
    int errCnt = 0;

    // Reference model state: architectural view only.
    logic [31:0] mPc, mInst, mInstPc;
    bit          mFault;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmpCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, ".reqValid"}, 32'(imem_req_valid), 0);
        chk({tag, ".addr"},     imem_req_addr, RESET_PC);
        chk({tag, ".instValid"},32'(inst_valid), 0);
        chk({tag, ".inst"},     inst, 0);
        chk({tag, ".instPc"},   inst_pc, RESET_PC);
        chk({tag, ".opcode"},   32'(opcode), 0);
        chk({tag, ".funct3"},   32'(funct3), 0);
        chk({tag, ".fault"},    32'(fetch_fault), 0);
    endtask

    task automatic checkInst(input string tag);
        chk({tag, ".instValid"}, 32'(inst_valid), 1);
        chk({tag, ".inst"},      inst, mInst);
        chk({tag, ".instPc"},    inst_pc, mInstPc);
        chk({tag, ".opcode"},    32'(opcode), 32'(mInst[6:0]));
        chk({tag, ".funct3"},    32'(funct3), 32'(mInst[14:12]));
    endtask

    task automatic modelReset();
        mPc = RESET_PC; mInst = '0; mInstPc = RESET_PC; mFault = 1'b0;
    endtask

    // Reset pulse; checks reset values and first-request timing.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkReset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        chk("rstIdleReq", 32'(imem_req_valid), 0);
        @(negedge clk);
        chk("firstReq", 32'(imem_req_valid), 1);
        chk("firstAddr", imem_req_addr, RESET_PC);
    endtask

    task automatic waitReq();
        for (int i = 0; i < 8 && !imem_req_valid; i++) @(negedge clk);
        chk("reqSeen", 32'(imem_req_valid), 1);
        chk("reqAddr", imem_req_addr, mPc);
    endtask

    // Stray response strobe while not in WAIT; must be ignored.
    task automatic strayResp();
        imem_resp_valid = 1'($urandom_range(0, 1));
        imem_resp_data  = $urandom;
        imem_resp_err   = 1'($urandom_range(0, 1));
    endtask

    task automatic quietResp();
        imem_resp_valid = 1'b0; imem_resp_err = 1'b0; imem_resp_data = $urandom;
    endtask

    // One full fetch transaction. respDelay = WAIT edges without a response
    // before the response edge; TIMEOUT or more means the memory never answers.
    task automatic fetchOne(input int reqDelay, input int respDelay, input logic [31:0] data,
                            input logic err, input int issueDelay, input logic [31:0] nextPc);
        waitReq();
        for (int i = 0; i < reqDelay; i++) begin
            @(negedge clk);
            chk("reqHold", 32'(imem_req_valid), 1);
            chk("reqAddrHold", imem_req_addr, mPc);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("reqDrop", 32'(imem_req_valid), 0);

        if (respDelay >= TIMEOUT) begin
            repeat (TIMEOUT - 1) @(negedge clk);
            chk("noFaultYet", 32'(fetch_fault), 0);
            @(negedge clk);
            mFault = 1'b1;
            chk("timeoutFault", 32'(fetch_fault), 1);
            chk("timeoutInstValid", 32'(inst_valid), 0);
            chk("timeoutInst", inst, mInst);
            return;
        end

        repeat (respDelay) @(negedge clk);
        chk("waitNoValid", 32'(inst_valid), 0);
        imem_resp_valid = 1'b1; imem_resp_data = data; imem_resp_err = err;
        @(negedge clk);
        quietResp();

        if (err) begin
            mFault = 1'b1;
            chk("errFault", 32'(fetch_fault), 1);
            chk("errInstValid", 32'(inst_valid), 0);
            chk("errReqValid", 32'(imem_req_valid), 0);
            chk("errInstKept", inst, mInst);
            return;
        end

        mInst = data; mInstPc = mPc;
        checkInst("issue");
        for (int i = 0; i < issueDelay; i++) begin
            strayResp();
            @(negedge clk);
            quietResp();
            checkInst("issueHold");
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("execInstValid", 32'(inst_valid), 0);
        chk("execReqValid", 32'(imem_req_valid), 0);

        for (int i = 0, n = $urandom_range(0, 3); i < n; i++) begin
            strayResp();
            @(negedge clk);
            quietResp();
            chk("execIdle", 32'(imem_req_valid), 0);
            chk("execInst", inst, mInst);
        end

        npc_valid = 1'b1; npc = nextPc;
        @(negedge clk);
        npc_valid = 1'b0; npc = $urandom;
        if (ALIGN && nextPc[1:0] != 2'b00) mFault = 1'b1;
        else mPc = nextPc;

        chk("nextFault", 32'(fetch_fault), 32'(mFault));
        chk("nextReq", 32'(imem_req_valid), 32'(!mFault));
        if (!mFault) chk("nextAddr", imem_req_addr, mPc);
    endtask

    // FAULT must hold through any activity until reset.
    task automatic faultHold(input int n);
        for (int i = 0; i < n; i++) begin
            npc_valid = 1'($urandom_range(0, 1)); npc = $urandom & 32'hFFFF_FFFC;
            imem_req_ready = 1'($urandom_range(0, 1));
            inst_ready = 1'($urandom_range(0, 1));
            strayResp();
            @(negedge clk);
            chk("faultSticky", 32'(fetch_fault), 1);
            chk("faultNoReq", 32'(imem_req_valid), 0);
            chk("faultNoInst", 32'(inst_valid), 0);
        end
        npc_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
        quietResp();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
        imem_resp_data = '0; inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;
        modelReset();
        #12;
        checkReset("por");
        doReset();

        // Basic fetch, decoder back-pressure, sequential next PC.
        fetchOne(0, 0, 32'h0010_0093, 1'b0, 5, 32'h8000_0004);
        // Request back-pressure then bus error.
        fetchOne(3, 2, $urandom, 1'b1, 0, 32'h0);
        faultHold(20);
        doReset();

        // Timeout boundary: no response ever.
        fetchOne(0, TIMEOUT, 32'h0, 1'b0, 0, 32'h0);
        faultHold(5);
        doReset();
        // Response on the timeout edge wins.
        fetchOne(0, TIMEOUT - 1, 32'h1234_5FB7, 1'b0, 1, 32'h8000_0010);

        // Reset pulse in WAIT, then a late response after release.
        waitReq();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkReset("midRst");
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        quietResp();
        chk("lateRespReq", 32'(imem_req_valid), 1);
        chk("lateRespAddr", imem_req_addr, RESET_PC);
        chk("lateRespInst", inst, 32'h0);
        fetchOne(1, 1, 32'h0000_0297, 1'b0, 2, 32'h8000_0002);

        // Misaligned npc: fault with the check, plain fetch without it.
        if (mFault) begin
            faultHold(5);
            doReset();
        end else begin
            fetchOne(0, 0, $urandom, 1'b0, 0, RESET_PC);
        end

        // Randomized traffic, including PC wrap-around near 2^32.
        for (int t = 0; t < 25; t++) begin
            logic [31:0] nxt;
            nxt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 2) * 4)
                                              : ($urandom & 32'hFFFF_FFFC);
            fetchOne($urandom_range(0, 3), $urandom_range(0, 6), $urandom, 1'b0,
                     $urandom_range(0, 4), nxt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
